// File: rtl/serial_pkg.sv
// Shared types and counter-width helpers for the serial shift-register chain.
// The frame loader and the chain top both size their counters from these helpers.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int bit_cnt_w(input int width);
    return cnt_w(width);
  endfunction

  function automatic int div_cnt_w(input int div);
    return cnt_w(div);
  endfunction

  function automatic int gap_cnt_w(input int gap, input int div);
    return cnt_w(gap * div + 1);
  endfunction

  // Accept-to-accept spacing when in_valid is held high.
  function automatic int frame_period(input int width, input int div, input int gap);
    return (width + gap) * div + 1;
  endfunction

endpackage

// File: rtl/bit_period_timer.sv
// Clock divider for one bit period: tick in the last cycle (count DIV-1), pre_tick one cycle earlier.
// Holds at zero while disabled so it never free-runs between frames.
module bit_period_timer
  import serial_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int DW = div_cnt_w(DIV);
  localparam logic [DW-1:0] TERM = DW'(DIV - 1);
  localparam logic [DW-1:0] PRE  = DW'((DIV >= 2) ? (DIV - 2) : 0);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == TERM) ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick     = en && (div_cnt == TERM);
  // Lets the caller register a strobe that lands in the last cycle of the period.
  assign pre_tick = en && (DIV >= 2) && (div_cnt == PRE);

endmodule

// File: rtl/serial_frame_loader.sv
// Accepts a parallel word on valid/ready and shifts it out MSB-first, one bit per DIV clocks,
// with a capture strobe per bit, a done pulse on the last strobe and GAP idle bit periods after.
module serial_frame_loader
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_strobe,
  output logic             ser_frame,
  output logic             done
);

  localparam int BW = bit_cnt_w(WIDTH);
  localparam int GW = gap_cnt_w(GAP, DIV);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? (GAP - 1) : 0);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nxt;
  logic [GW-1:0]    gap_cnt;
  logic             accept;
  logic             timer_en;
  logic             tick;
  logic             pre_tick;

  assign accept    = (state == S_IDLE) && in_valid && in_ready;
  assign timer_en  = (state == S_SHIFT) || (state == S_GAP);
  assign shreg_nxt = shreg << 1;
  assign bit_nxt   = bit_cnt + 1'b1;

  bit_period_timer #(.DIV(DIV)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (timer_en),
    .clear    (accept),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // All outputs are registered: each branch computes what the next cycle must show.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      in_ready   <= 1'b0;
      ser_data   <= 1'b0;
      ser_strobe <= 1'b0;
      ser_frame  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_SHIFT;
            shreg      <= in_data;
            bit_cnt    <= '0;
            in_ready   <= 1'b0;
            ser_data   <= in_data[WIDTH-1];
            ser_frame  <= 1'b1;
            ser_strobe <= (DIV == 1);
            done       <= (DIV == 1) && (WIDTH == 1);
          end else begin
            in_ready <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              shreg      <= '0;
              ser_data   <= 1'b0;
              ser_frame  <= 1'b0;
              ser_strobe <= 1'b0;
              done       <= 1'b0;
              if (GAP > 0) begin
                state <= S_GAP;
              end else begin
                state    <= S_IDLE;
                in_ready <= 1'b1;
              end
            end else begin
              bit_cnt    <= bit_nxt;
              shreg      <= shreg_nxt;
              ser_data   <= shreg_nxt[WIDTH-1];
              ser_strobe <= (DIV == 1);
              done       <= (DIV == 1) && (bit_nxt == LAST_BIT);
            end
          end else begin
            ser_strobe <= pre_tick;
            done       <= pre_tick && (bit_cnt == LAST_BIT);
          end
        end

        S_GAP: begin
          // The timer keeps running through the gap; count whole idle bit periods.
          if (tick) begin
            if (gap_cnt == LAST_GAP) begin
              gap_cnt  <= '0;
              state    <= S_IDLE;
              in_ready <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
